axicb_resp_order_tracker: RTL and testbench

- Return-path companion of the round-robin arbiter core.
- On each accepted arbitrated request, it records the one-hot grant in an in-order FIFO.
- It then steers response beats from the single slave side back to the originating requester, and retires the entry on the last beat.
- It back-pressures the arbiter when the outstanding-request capacity is exhausted.

---
 rtl/axicb_order_pkg.sv | 27 ++
 rtl/axicb_order_fifo.sv | 80 ++++++++
 rtl/axicb_resp_order_tracker.sv | 93 +++++++++
 tb/tb_axicb_resp_order_tracker.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/axicb_order_pkg.sv
// Shared helpers for the response order tracker.
// Holds the grant one-hot check and the pointer/count width helpers
// derived from the outstanding depth.
package axicb_order_pkg;

   // Widest grant vector supported; narrower grants are zero-extended.
   localparam int unsigned GrantMaxW   = 8;
   localparam int unsigned OstdNbDflt  = 4;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // One extra bit so the count can represent a completely full FIFO.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int unsigned PtrWDflt = ptr_width(OstdNbDflt);
   localparam int unsigned CntWDflt = cnt_width(OstdNbDflt);

   // True when exactly one bit of grant is set.
   function automatic logic onehot_check(input logic [GrantMaxW-1:0] grant);
      return (grant != '0) && ((grant & (grant - GrantMaxW'(1))) == '0);
   endfunction

endpackage

// File: rtl/axicb_order_fifo.sv
// In-order FIFO of grant vectors for the response order tracker.
// Ports:
//   clk_i, aresetn_i (async active-low), srst_i (sync active-high)
//   push_i/data_i  : write request; ignored while full
//   pop_i          : retire head; ignored while empty
//   head_o         : entry at the read pointer, read combinationally
//   full_o, empty_o, cnt_o : occupancy, derived from registered state only
module axicb_order_fifo
   import axicb_order_pkg::*;
#(
   parameter int unsigned Width = 4,
   parameter int unsigned Depth = 4
) (
   input  logic                       clk_i,
   input  logic                       aresetn_i,
   input  logic                       srst_i,
   input  logic                       push_i,
   input  logic [Width-1:0]           data_i,
   input  logic                       pop_i,
   output logic [Width-1:0]           head_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [cnt_width(Depth)-1:0] cnt_o
);

   localparam int unsigned PtrW = ptr_width(Depth);
   localparam int unsigned CntW = cnt_width(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             push_en, pop_en;

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign cnt_o   = cnt_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign push_en = push_i & ~full_o;
   assign pop_en  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (srst_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         // Pointers wrap by natural overflow since Depth is a power of two.
         if (push_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop_en)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         unique case ({push_en, pop_en})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: entries are only observed while counted.
   always_ff @(posedge clk_i) begin
      if (push_en && !srst_i) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/axicb_resp_order_tracker.sv
// Return-path companion of the round-robin arbiter: records each accepted
// one-hot grant in order and steers slave response beats back to the
// originating requester, retiring the entry on the last beat.
// Ports:
//   aclk, aresetn (async active-low), srst (sync active-high)
//   req_grant/req_accept : accepted arbitration result to record
//   req_full, ostd_cnt   : back-pressure and outstanding count
//   s_valid/s_ready/s_last/s_data : single slave response channel
//   m_valid/m_ready      : per-requester response handshake
//   m_last/m_data        : broadcast response beat
//   err                  : sticky protocol error, only with
//                          AXICB_RESP_ORDER_CHECK_EN defined
module axicb_resp_order_tracker
   import axicb_order_pkg::*;
#(
   parameter int unsigned REQ_NB  = 4,
   parameter int unsigned OSTD_NB = 4,
   parameter int unsigned DATA_W  = 32
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       srst,
   input  logic [REQ_NB-1:0]          req_grant,
   input  logic                       req_accept,
   output logic                       req_full,
   output logic [$clog2(OSTD_NB):0]   ostd_cnt,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic                       s_last,
   input  logic [DATA_W-1:0]          s_data,
   output logic [REQ_NB-1:0]          m_valid,
   input  logic [REQ_NB-1:0]          m_ready,
   output logic                       m_last,
   output logic [DATA_W-1:0]          m_data
`ifdef AXICB_RESP_ORDER_CHECK_EN
   ,
   output logic                       err
`endif
);

   logic [REQ_NB-1:0] head;
   logic              empty;
   logic              pop;

   // Pop only on the handshake of the final beat of a response.
   assign pop = s_valid & s_ready & s_last;

   axicb_order_fifo #(
      .Width (REQ_NB),
      .Depth (OSTD_NB)
   ) u_fifo (
      .clk_i     (aclk),
      .aresetn_i (aresetn),
      .srst_i    (srst),
      .push_i    (req_accept),
      .data_i    (req_grant),
      .pop_i     (pop),
      .head_o    (head),
      .full_o    (req_full),
      .empty_o   (empty),
      .cnt_o     (ostd_cnt)
   );

   assign m_valid = head & {REQ_NB{s_valid & ~empty}};
   assign s_ready = ~empty & (|(head & m_ready));
   assign m_data  = s_data;
   assign m_last  = s_last;

`ifdef AXICB_RESP_ORDER_CHECK_EN
   logic err_q, err_d;
   logic push_en;

   assign push_en = req_accept & ~req_full;

   always_comb begin
      err_d = err_q;
      if (srst) begin
         err_d = 1'b0;
      end else begin
         if (push_en && !onehot_check(GrantMaxW'(req_grant))) err_d = 1'b1;
         if (s_valid && empty) err_d = 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) err_q <= 1'b0;
      else          err_q <= err_d;
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_axicb_resp_order_tracker.sv
// Directed bench for axicb_resp_order_tracker (REQ_NB=4, OSTD_NB=4).
module tb_axicb_resp_order_tracker;

   logic        aclk;
   logic        aresetn;
   logic        srst;
   logic [3:0]  req_grant;
   logic        req_accept;
   logic        req_full;
   logic [2:0]  ostd_cnt;
   logic        s_valid;
   logic        s_ready;
   logic        s_last;
   logic [31:0] s_data;
   logic [3:0]  m_valid;
   logic [3:0]  m_ready;
   logic        m_last;
   logic [31:0] m_data;
`ifdef AXICB_RESP_ORDER_CHECK_EN
   logic        err;
`endif

   int checks = 0;
   int errors = 0;

   axicb_resp_order_tracker #(
      .REQ_NB  (4),
      .OSTD_NB (4),
      .DATA_W  (32)
   ) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .srst       (srst),
      .req_grant  (req_grant),
      .req_accept (req_accept),
      .req_full   (req_full),
      .ostd_cnt   (ostd_cnt),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_last     (s_last),
      .s_data     (s_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last),
      .m_data     (m_data)
`ifdef AXICB_RESP_ORDER_CHECK_EN
      ,
      .err        (err)
`endif
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are
   // sampled 1-2 time units after the edge.
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic push(input logic [3:0] g);
      req_grant  = g;
      req_accept = 1'b1;
      tick();
      req_accept = 1'b0;
      req_grant  = 4'b0000;
   endtask

   // Single-beat response; checks the routed head before the pop edge.
   task automatic resp1(input string tag, input logic [3:0] exp_head);
      s_valid = 1'b1;
      s_last  = 1'b1;
      #1;
      check_eq(tag, 32'(m_valid), 32'(exp_head));
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   initial begin
      aresetn    = 1'b0;
      srst       = 1'b0;
      req_grant  = 4'b0000;
      req_accept = 1'b0;
      s_valid    = 1'b0;
      s_last     = 1'b0;
      s_data     = 32'h0;
      m_ready    = 4'b1111;
      #12;
      check_eq("rst_full", 32'(req_full), 32'd0);
      check_eq("rst_cnt", 32'(ostd_cnt), 32'd0);
      check_eq("rst_mvalid", 32'(m_valid), 32'd0);
      check_eq("rst_sready", 32'(s_ready), 32'd0);
      aresetn = 1'b1;
      tick();

      // Single request, 3-beat response; no bypass in the push cycle.
      req_grant  = 4'b0100;
      req_accept = 1'b1;
      s_valid    = 1'b1;
      s_data     = 32'hA1;
      #1;
      check_eq("nobypass_mvalid", 32'(m_valid), 32'd0);
      check_eq("nobypass_sready", 32'(s_ready), 32'd0);
      tick();
      req_accept = 1'b0;
      check_eq("single_cnt1", 32'(ostd_cnt), 32'd1);
      for (int b = 0; b < 3; b++) begin
         s_data = 32'hA1 + 32'(b);
         s_last = (b == 2);
         #1;
         check_eq("single_mvalid", 32'(m_valid), 32'b0100);
         check_eq("single_sready", 32'(s_ready), 32'd1);
         check_eq("single_mdata", m_data, 32'hA1 + 32'(b));
         check_eq("single_mlast", 32'(m_last), (b == 2) ? 32'd1 : 32'd0);
         tick();
         if (b < 2) check_eq("single_cnt_hold", 32'(ostd_cnt), 32'd1);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      #1;
      check_eq("single_cnt0", 32'(ostd_cnt), 32'd0);
      check_eq("single_sready0", 32'(s_ready), 32'd0);

      // In-order routing.
      push(4'b0001);
      push(4'b1000);
      push(4'b0010);
      check_eq("order_cnt3", 32'(ostd_cnt), 32'd3);
      resp1("order_r0", 4'b0001);
      resp1("order_r1", 4'b1000);
      resp1("order_r2", 4'b0010);
      check_eq("order_cnt0", 32'(ostd_cnt), 32'd0);

      // Full back-pressure; the ignored 5th push must not overwrite slot 0.
      push(4'b0001);
      push(4'b0010);
      push(4'b0100);
      push(4'b1000);
      check_eq("full_flag", 32'(req_full), 32'd1);
      check_eq("full_cnt4", 32'(ostd_cnt), 32'd4);
      push(4'b0100);
      check_eq("full_ign_cnt", 32'(ostd_cnt), 32'd4);
      resp1("full_head", 4'b0001);
      check_eq("full_clear", 32'(req_full), 32'd0);
      check_eq("full_cnt3", 32'(ostd_cnt), 32'd3);
      resp1("full_head2", 4'b0010);

      // Simultaneous push and pop at count 2 (entries 0100, 1000).
      check_eq("sim_cnt_pre", 32'(ostd_cnt), 32'd2);
      req_grant  = 4'b0010;
      req_accept = 1'b1;
      resp1("sim_head", 4'b0100);
      req_accept = 1'b0;
      check_eq("sim_cnt", 32'(ostd_cnt), 32'd2);
      resp1("sim_next", 4'b1000);
      resp1("sim_pushed", 4'b0010);
      check_eq("sim_cnt0", 32'(ostd_cnt), 32'd0);

      // Stall on head requester not ready, then async reset mid-burst.
      push(4'b0100);
      push(4'b0001);
      m_ready = 4'b1011;
      s_valid = 1'b1;
      s_data  = 32'hDEAD;
      #1;
      check_eq("stall_sready", 32'(s_ready), 32'd0);
      check_eq("stall_mvalid", 32'(m_valid), 32'b0100);
      check_eq("stall_mdata", m_data, 32'hDEAD);
      tick();
      check_eq("stall_cnt", 32'(ostd_cnt), 32'd2);
      check_eq("stall_hold", 32'(m_valid), 32'b0100);
      m_ready = 4'b1111;
      tick();
      #2;
      aresetn = 1'b0;
      #1;
      check_eq("arst_cnt", 32'(ostd_cnt), 32'd0);
      check_eq("arst_mvalid", 32'(m_valid), 32'd0);
      check_eq("arst_sready", 32'(s_ready), 32'd0);
      #1;
      aresetn = 1'b1;
      tick();
      check_eq("arst_stall", 32'(m_valid), 32'd0);
      check_eq("arst_cnt_after", 32'(ostd_cnt), 32'd0);
      s_valid = 1'b0;

      // Synchronous reset has priority over a simultaneous push.
      push(4'b0001);
      push(4'b0010);
      srst       = 1'b1;
      req_grant  = 4'b0100;
      req_accept = 1'b1;
      tick();
      srst       = 1'b0;
      req_accept = 1'b0;
      check_eq("srst_cnt", 32'(ostd_cnt), 32'd0);
      check_eq("srst_full", 32'(req_full), 32'd0);

`ifdef AXICB_RESP_ORDER_CHECK_EN
      check_eq("err_clear", 32'(err), 32'd0);
      push(4'b0110);
      check_eq("err_grant", 32'(err), 32'd1);
      check_eq("err_stored", 32'(ostd_cnt), 32'd1);
      tick();
      check_eq("err_sticky", 32'(err), 32'd1);
      srst = 1'b1;
      tick();
      srst = 1'b0;
      check_eq("err_srst", 32'(err), 32'd0);
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      check_eq("err_empty_resp", 32'(err), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
